// File: rtl/acsp_uart_pkg.sv
// Shared types and helpers for the ACSP UART receive path.
// Also reused by the planned transmit path.
package acsp_uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Rounded clocks-per-tick. The arithmetic is done in 64 bits so that fast
    // system clocks cannot overflow the intermediate product.
    function automatic int calc_tick_div(input int clk_khz, input int baud, input int os);
        longint num;
        longint den;
        num = longint'(clk_khz) * 64'sd1000;
        den = longint'(baud) * longint'(os);
        return int'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/acsp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered occupancy count.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module acsp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;
    logic             w_full;

    assign w_full  = (r_count == (AW + 1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_data  = r_mem[r_rdPtr];
    assign o_valid = (r_count != '0);
    assign o_full  = w_full;
    assign o_count = r_count;

    // Storage is cleared on reset so the head word reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/acsp_uart_rx.sv
// Parametrised UART receiver: synchroniser, oversampling tick divider,
// majority-vote mid-bit sampling, framing/break detection and a FWFT receive FIFO.
module acsp_uart_rx #(
    parameter int INPUT_CLK_KHZ = 100000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          system_clock,
    input  logic                          ext_reset_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          break_det,
    input  logic                          err_clear
);

    import acsp_uart_pkg::*;

    localparam int      TICK_DIV = calc_tick_div(INPUT_CLK_KHZ, BAUD_RATE, OVERSAMPLE);
    localparam int      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int      OS_W     = $clog2(OVERSAMPLE);
    localparam int      BC_W     = 4;
    localparam parity_e PAR_MODE = parity_e'(PARITY);
    localparam logic [OS_W-1:0] SAMP0 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] SAMP1 = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] SAMP2 = OS_W'(OVERSAMPLE / 2 + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxPrev;
    logic [DIV_W-1:0]       r_divCnt;
    logic [OS_W-1:0]        r_tickCnt;
    logic                   r_s0;
    logic                   r_s1;
    logic [BC_W-1:0]        r_bitCnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parErr;
    logic                   r_stopLow;
    logic                   r_frameErr;
    logic                   r_overrun;
    logic                   r_breakDet;
    rx_state_e              r_state;
    rx_state_e              w_nextState;

    logic w_rxs;
    logic w_fall;
    logic w_startEdge;
    logic w_tick;
    logic w_sampleEvt;
    logic w_bit;
    logic w_expPar;
    logic w_stopLow;
    logic w_push;
    logic w_setFrame;
    logic w_setBreak;
    logic w_clrBreak;
    logic w_fifoFull;

    assign w_rxs       = r_sync[SYNC_STAGES-1];
    assign w_fall      = r_rxPrev && !w_rxs;
    assign w_startEdge = (r_state == IDLE) && w_fall;
    assign w_tick      = (r_divCnt == DIV_W'(TICK_DIV - 1));
    assign w_sampleEvt = w_tick && (r_tickCnt == SAMP2) && (r_state != IDLE) && (r_state != BREAK);
    assign w_bit       = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_expPar    = (PAR_MODE == ODD) ? ~^r_shift : ^r_shift;
    assign w_stopLow   = r_stopLow | ~w_bit;

    // Synchroniser idles high so reset release never looks like a start edge.
    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_sync   <= '1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rxPrev <= w_rxs;
        end
    end

    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_divCnt  <= '0;
            r_tickCnt <= '0;
        end else if (w_startEdge) begin
            r_divCnt  <= '0;
            r_tickCnt <= '0;
        end else begin
            r_divCnt <= w_tick ? '0 : r_divCnt + DIV_W'(1);
            if (w_tick) begin
                r_tickCnt <= (r_tickCnt == OS_W'(OVERSAMPLE - 1)) ? '0 : r_tickCnt + OS_W'(1);
            end
        end
    end

    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Every bit decision is taken at the third vote sample, including the last stop bit.
    always_comb begin
        w_nextState = r_state;
        w_push      = 1'b0;
        w_setFrame  = 1'b0;
        w_setBreak  = 1'b0;
        w_clrBreak  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall) w_nextState = START;
            end
            START: begin
                if (w_sampleEvt) w_nextState = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_sampleEvt && (r_bitCnt == BC_W'(DATA_BITS - 1))) begin
                    w_nextState = (PAR_MODE != NONE) ? acsp_uart_pkg::PARITY : STOP;
                end
            end
            acsp_uart_pkg::PARITY: begin
                if (w_sampleEvt) w_nextState = STOP;
            end
            STOP: begin
                if (w_sampleEvt && (r_bitCnt == BC_W'(STOP_BITS - 1))) begin
                    if (!w_stopLow) begin
                        w_push      = 1'b1;
                        w_nextState = IDLE;
                    end else if (r_shift == '0) begin
                        w_setBreak  = 1'b1;
                        w_nextState = BREAK;
                    end else begin
                        w_setFrame  = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_clrBreak  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_parErr  <= 1'b0;
            r_stopLow <= 1'b0;
        end else begin
            if (w_tick && (r_tickCnt == SAMP0)) r_s0 <= w_rxs;
            if (w_tick && (r_tickCnt == SAMP1)) r_s1 <= w_rxs;
            if (r_state != w_nextState) begin
                r_bitCnt <= '0;
            end else if (w_sampleEvt) begin
                r_bitCnt <= r_bitCnt + BC_W'(1);
            end
            if (w_sampleEvt) begin
                if (r_state == START) begin
                    r_parErr  <= 1'b0;
                    r_stopLow <= 1'b0;
                end
                if (r_state == DATA) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                if (r_state == acsp_uart_pkg::PARITY) r_parErr <= (w_bit != w_expPar);
                if (r_state == STOP) r_stopLow <= w_stopLow;
            end
        end
    end

    // A fresh error event outranks a simultaneous clear.
    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
            r_breakDet <= 1'b0;
        end else begin
            r_frameErr <= w_setFrame | (r_frameErr & ~err_clear);
            r_overrun  <= (w_push && w_fifoFull && !(rx_valid && rx_ready)) | (r_overrun & ~err_clear);
            if (w_setBreak) begin
                r_breakDet <= 1'b1;
            end else if (w_clrBreak) begin
                r_breakDet <= 1'b0;
            end
        end
    end

    acsp_sync_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (system_clock),
        .rst_n   (ext_reset_n),
        .i_push  (w_push),
        .i_data  ({r_parErr, r_shift}),
        .i_pop   (rx_ready),
        .o_data  ({rx_parity_err, rx_data}),
        .o_valid (rx_valid),
        .o_full  (w_fifoFull),
        .o_count (fifo_count)
    );

    assign frame_err   = r_frameErr;
    assign overrun_err = r_overrun;
    assign break_det   = r_breakDet;

endmodule

// File: tb/tb_acsp_uart_rx.sv
// Directed bench for acsp_uart_rx: an 8N1 instance and an even-parity instance,
// both run at a fast baud (4 clocks per tick, 64 clocks per bit).
module tb_acsp_uart_rx;

    localparam int CLK_KHZ  = 100000;
    localparam int BAUD     = 1562500;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       rxLine;
    logic       rxPar;
    logic       rxReady;
    logic       parReady;
    logic       errClear;

    logic [7:0] data;
    logic       parErr;
    logic       valid;
    logic [2:0] count;
    logic       frameErr;
    logic       overrunErr;
    logic       breakDet;

    logic [7:0] pData;
    logic       pParErr;
    logic       pValid;
    logic [2:0] pCount;
    logic       pFrameErr;
    logic       pOverrun;
    logic       pBreak;

    int errorCount = 0;
    int checkCount = 0;
    int validCycles = 0;
    logic [8:0] rxQ[$];
    logic [8:0] parQ[$];

    acsp_uart_rx #(
        .INPUT_CLK_KHZ (CLK_KHZ),
        .BAUD_RATE     (BAUD),
        .OVERSAMPLE    (OS)
    ) dut (
        .system_clock  (clk),
        .ext_reset_n   (rstN),
        .rx            (rxLine),
        .rx_data       (data),
        .rx_parity_err (parErr),
        .rx_valid      (valid),
        .rx_ready      (rxReady),
        .fifo_count    (count),
        .frame_err     (frameErr),
        .overrun_err   (overrunErr),
        .break_det     (breakDet),
        .err_clear     (errClear)
    );

    acsp_uart_rx #(
        .INPUT_CLK_KHZ (CLK_KHZ),
        .BAUD_RATE     (BAUD),
        .OVERSAMPLE    (OS),
        .PARITY        (2)
    ) dutPar (
        .system_clock  (clk),
        .ext_reset_n   (rstN),
        .rx            (rxPar),
        .rx_data       (pData),
        .rx_parity_err (pParErr),
        .rx_valid      (pValid),
        .rx_ready      (parReady),
        .fifo_count    (pCount),
        .frame_err     (pFrameErr),
        .overrun_err   (pOverrun),
        .break_det     (pBreak),
        .err_clear     (errClear)
    );

    // Every accepted word (valid && ready) is logged on the falling edge.
    always @(negedge clk) begin
        if (rstN) begin
            if (valid) validCycles++;
            if (valid && rxReady) rxQ.push_back({parErr, data});
            if (pValid && parReady) parQ.push_back({pParErr, pData});
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleBits(input int n);
        repeat (n * BIT_CLKS) waitCycle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Serialises bits[0] first, one bit time each, then returns the line to idle.
    task automatic applyStimulus(input logic [15:0] bits, input int nbits, input bit toPar);
        for (int i = 0; i < nbits; i++) begin
            if (toPar) rxPar = bits[i];
            else rxLine = bits[i];
            repeat (BIT_CLKS) waitCycle();
        end
        if (toPar) rxPar = 1'b1;
        else rxLine = 1'b1;
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] framePar(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [31:0] popRx();
        if (rxQ.size() == 0) return 32'hBAD;
        return {23'b0, rxQ.pop_front()};
    endfunction

    function automatic logic [31:0] popPar();
        if (parQ.size() == 0) return 32'hBAD;
        return {23'b0, parQ.pop_front()};
    endfunction

    initial begin
        int v0;
        rstN     = 1'b0;
        rxLine   = 1'b1;
        rxPar    = 1'b1;
        rxReady  = 1'b1;
        parReady = 1'b1;
        errClear = 1'b0;
        repeat (5) waitCycle();

        checkOutput("tickdiv 115200", acsp_uart_pkg::calc_tick_div(100000, 115200, 16), 54);
        checkOutput("tickdiv bench", acsp_uart_pkg::calc_tick_div(CLK_KHZ, BAUD, OS), 4);

        rstN = 1'b1;
        idleBits(2);

        // Reset in the middle of a frame, then a clean frame.
        applyStimulus(frame8(8'h55), 4, 1'b0);
        rstN   = 1'b0;
        rxLine = 1'b1;
        repeat (3) waitCycle();
        rstN = 1'b1;
        waitCycle();
        checkOutput("rst rx_data", data, 0);
        checkOutput("rst parity_err", parErr, 0);
        checkOutput("rst rx_valid", valid, 0);
        checkOutput("rst fifo_count", count, 0);
        checkOutput("rst frame_err", frameErr, 0);
        checkOutput("rst overrun_err", overrunErr, 0);
        checkOutput("rst break_det", breakDet, 0);
        idleBits(2);
        checkOutput("rst no partial push", rxQ.size(), 0);
        applyStimulus(frame8(8'h55), 10, 1'b0);
        idleBits(1);
        checkOutput("t1 word 55", popRx(), 32'h055);

        // Plain 8N1 word with ready held high.
        v0 = validCycles;
        applyStimulus(frame8(8'hA5), 10, 1'b0);
        idleBits(1);
        checkOutput("t2 word A5", popRx(), 32'h0A5);
        checkOutput("t2 valid one cycle", validCycles - v0, 1);
        checkOutput("t2 frame_err", frameErr, 0);
        checkOutput("t2 overrun_err", overrunErr, 0);
        checkOutput("t2 break_det", breakDet, 0);

        // Three-tick glitch is a false start.
        rxLine = 1'b0;
        repeat (12) waitCycle();
        rxLine = 1'b1;
        idleBits(2);
        checkOutput("t3 glitch no push", rxQ.size(), 0);
        checkOutput("t3 glitch frame_err", frameErr, 0);
        applyStimulus(frame8(8'h3C), 10, 1'b0);
        idleBits(1);
        checkOutput("t3 word 3C", popRx(), 32'h03C);

        // Even parity: 0x81 has two ones, so the correct parity bit is 0.
        applyStimulus(framePar(8'h81, 1'b1), 11, 1'b1);
        idleBits(1);
        checkOutput("t4 bad parity", popPar(), 32'h181);
        applyStimulus(framePar(8'h81, 1'b0), 11, 1'b1);
        idleBits(1);
        checkOutput("t4 good parity", popPar(), 32'h081);
        checkOutput("t4 par frame_err", pFrameErr, 0);

        // Fill the FIFO past capacity with the consumer stalled.
        rxReady = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            applyStimulus(frame8(8'(d)), 10, 1'b0);
        end
        idleBits(1);
        checkOutput("t5 fifo_count full", count, 4);
        checkOutput("t5 overrun_err set", overrunErr, 1);
        checkOutput("t5 rx_valid", valid, 1);
        checkOutput("t5 head held", data, 8'h01);
        checkOutput("t5 frame_err", frameErr, 0);
        for (int i = 0; i < 4; i++) begin
            rxReady = 1'b1;
            waitCycle();
            rxReady = 1'b0;
            waitCycle();
        end
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("t5 pop %0d", i), popRx(), 32'(i));
        end
        checkOutput("t5 drained count", count, 0);
        checkOutput("t5 drained valid", valid, 0);
        checkOutput("t5 overrun sticky", overrunErr, 1);
        errClear = 1'b1;
        waitCycle();
        errClear = 1'b0;
        checkOutput("t5 overrun cleared", overrunErr, 0);

        // Break: line held low for twelve bit times.
        rxReady = 1'b1;
        rxLine  = 1'b0;
        idleBits(12);
        checkOutput("t6 break_det set", breakDet, 1);
        checkOutput("t6 break frame_err", frameErr, 0);
        checkOutput("t6 break no push", rxQ.size(), 0);
        rxLine = 1'b1;
        repeat (8) waitCycle();
        checkOutput("t6 break_det clear", breakDet, 0);
        idleBits(1);

        // Stop bit forced low on non-zero data is a framing error.
        applyStimulus({6'b0, 1'b0, 8'h7E, 1'b0}, 10, 1'b0);
        idleBits(1);
        checkOutput("t6 frame_err set", frameErr, 1);
        checkOutput("t6 frame no push", rxQ.size(), 0);
        checkOutput("t6 frame no break", breakDet, 0);
        errClear = 1'b1;
        waitCycle();
        errClear = 1'b0;
        checkOutput("t6 frame_err cleared", frameErr, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
